// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and parity-mode encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; head word is visible on rdata.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic             push_ok;
  logic             pop_ok;

  // Full comes from the registered level, so a push on a full FIFO is refused even if a pop happens on the same edge.
  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];
  assign level   = level_q;

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset && push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with internal baud divider and a small transmit queue.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DIV        = 5208,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        sysclk,
  input  logic                        reset,
  input  logic [DATA_BITS-1:0]        TX_DATA,
  input  logic                        TX_EN,
  output logic                        TX_STATUS,
  output logic                        TX_BUSY,
  output logic                        TX_OVF,
  output logic [$clog2(FIFO_DEPTH):0] TX_LEVEL,
  output logic                        TX
);

  localparam int unsigned DIV_W = $clog2(DIV);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  tx_state_e              state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   ovf_q;

  logic                   fifo_pop;
  logic [DATA_BITS-1:0]   fifo_rdata;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   bit_end;
  logic                   load;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sysclk (sysclk),
    .reset  (reset),
    .push   (TX_EN),
    .wdata  (TX_DATA),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (TX_LEVEL)
  );

  assign bit_end   = (div_q == DIV_W'(DIV - 1));
  assign TX        = tx_q;
  assign TX_OVF    = ovf_q;
  assign TX_STATUS = ~fifo_full;
  assign TX_BUSY   = (state_q != ST_IDLE) | ~fifo_empty;

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ovf_q   <= TX_EN & fifo_full;
    end
  end

  // Next-state and next-bit logic; tx_d is the value the line takes after the coming edge.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
    div_d    = (state_q == ST_IDLE || bit_end) ? '0 : div_q + DIV_W'(1);

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        load = ~fifo_empty;
      end
      ST_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          par_d   = par_q ^ shift_q[0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            if (PARITY != PAR_NONE) begin
              tx_d    = (PARITY == PAR_EVEN) ? par_q : ~par_q;
              state_d = ST_PARITY;
            end else begin
              tx_d    = 1'b1;
              stop_d  = 1'b0;
              state_d = ST_STOP;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            par_d   = par_q ^ shift_q[0];
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          stop_d  = 1'b0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
            load    = ~fifo_empty;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    // Starting a frame from IDLE or straight out of STOP keeps back-to-back frames gapless.
    if (load) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_rdata;
      par_d    = 1'b0;
      idx_d    = '0;
      div_d    = '0;
      tx_d     = 1'b0;
      state_d  = ST_START;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: four transmitter configurations, each with a per-cycle line monitor.
module tb_uart_tx_fifo;

  logic       sysclk;
  logic       reset;
  logic       en     [4];
  logic [8:0] din    [4];
  logic       status [4];
  logic       busy   [4];
  logic       ovf    [4];
  logic [2:0] level  [4];
  logic       tx     [4];

  int vectors;
  int errors;
  int n;

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge sysclk);
  endtask

  task automatic wait_idle(input int g, output int cnt);
    cnt = 0;
    while (busy[g] && cnt < 2000) begin
      tick();
      cnt++;
    end
  endtask

  // Queue one word, check the pop edge, then the cycle count until the line goes idle.
  task automatic send_one(input int g, input logic [8:0] d, input int frame_len);
    int cnt;
    din[g] = d;
    en[g]  = 1'b1;
    tick();
    en[g]  = 1'b0;
    check($sformatf("lvl_after_accept%0d", g), 32'(level[g]), 32'd1);
    tick();
    check($sformatf("start_bit%0d", g), 32'(tx[g]), 32'd0);
    check($sformatf("lvl_after_pop%0d", g), 32'(level[g]), 32'd0);
    wait_idle(g, cnt);
    check($sformatf("frame_len%0d", g), 32'(cnt), 32'(frame_len));
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned D   = (g == 3) ? 2 : 4;
    localparam int unsigned DB  = (g == 3) ? 5 : 8;
    localparam int unsigned PAR = (g == 1) ? 2 : (g == 2) ? 1 : 0;
    localparam int unsigned SB  = (g == 1) ? 2 : 1;
    localparam int unsigned LEN = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;

    logic [15:0] q [$];
    logic [15:0] cur;
    logic        acc;
    logic [8:0]  acc_data;
    bit          active;
    int          cyc;
    int          frames;

    uart_tx_fifo #(
      .DIV        (D),
      .DATA_BITS  (DB),
      .PARITY     (PAR),
      .STOP_BITS  (SB),
      .FIFO_DEPTH (4)
    ) dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .TX_DATA   (din[g][DB-1:0]),
      .TX_EN     (en[g]),
      .TX_STATUS (status[g]),
      .TX_BUSY   (busy[g]),
      .TX_OVF    (ovf[g]),
      .TX_LEVEL  (level[g]),
      .TX        (tx[g])
    );

    // Expected line levels, one entry per bit period: start, data LSB first, parity, stops.
    function automatic logic [15:0] frame_of(input logic [8:0] d);
      logic [15:0] f;
      logic        p;
      f = '1;
      f[0] = 1'b0;
      p = 1'b0;
      for (int i = 0; i < int'(DB); i++) begin
        f[1 + i] = d[i];
        p = p ^ d[i];
      end
      if (PAR != 0) f[1 + DB] = (PAR == 2) ? p : ~p;
      return f;
    endfunction

    always @(posedge sysclk) begin
      acc      = reset && en[g] && status[g];
      acc_data = din[g];
    end

    initial begin
      acc = 1'b0; active = 1'b0; cyc = 0; frames = 0; cur = '0; acc_data = '0;
    end

    always @(negedge sysclk) begin
      if (!reset) begin
        q.delete();
        active = 1'b0;
      end else begin
        if (acc) q.push_back(frame_of(acc_data));
        acc = 1'b0;
        if (!active && tx[g] == 1'b0 && q.size() > 0) begin
          cur    = q.pop_front();
          active = 1'b1;
          cyc    = 0;
        end
        if (active) begin
          check($sformatf("tx%0d_bit%0d", g, cyc / int'(D)), 32'(tx[g]), 32'(cur[cyc / int'(D)]));
          cyc++;
          if (cyc == int'(LEN * D)) begin
            active = 1'b0;
            frames++;
          end
        end else if (q.size() == 0) begin
          check($sformatf("tx%0d_idle", g), 32'(tx[g]), 32'd1);
        end
      end
    end
  end

  initial begin
    vectors = 0;
    errors  = 0;
    reset   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      en[k]  = 1'b0;
      din[k] = '0;
    end
    repeat (3) tick();
    check("rst_tx",     32'(tx[0]),     32'd1);
    check("rst_status", 32'(status[0]), 32'd1);
    check("rst_busy",   32'(busy[0]),   32'd0);
    check("rst_ovf",    32'(ovf[0]),    32'd0);
    check("rst_level",  32'(level[0]),  32'd0);
    reset = 1'b1;
    tick();

    // 8N1 single frame
    send_one(0, 9'h055, 40);

    // 8E2 and 8O1 on 0x07, started on the same edge
    din[1] = 9'h007; din[2] = 9'h007;
    en[1] = 1'b1; en[2] = 1'b1;
    tick();
    en[1] = 1'b0; en[2] = 1'b0;
    tick();
    wait_idle(2, n);
    check("frame_8o1", 32'(n), 32'd44);
    wait_idle(1, n);
    check("frame_8e2_rest", 32'(n), 32'd4);

    // Six consecutive writes: five accepted, sixth dropped
    for (int i = 0; i < 6; i++) begin
      din[0] = 9'(i + 1);
      en[0]  = 1'b1;
      tick();
      if (i == 3) check("ovf_before_full", 32'(ovf[0]), 32'd0);
      if (i == 4) begin
        check("full_level",  32'(level[0]),  32'd4);
        check("full_status", 32'(status[0]), 32'd0);
      end
    end
    en[0] = 1'b0;
    check("ovf_pulse", 32'(ovf[0]), 32'd1);
    check("ovf_level", 32'(level[0]), 32'd4);
    tick();
    check("ovf_clear", 32'(ovf[0]), 32'd0);
    wait_idle(0, n);
    check("fill_drain", 32'(n), 32'd195);

    // Three queued words, gapless
    for (int i = 0; i < 3; i++) begin
      din[0] = (i == 0) ? 9'h0A5 : (i == 1) ? 9'h03C : 9'h0F0;
      en[0]  = 1'b1;
      tick();
    end
    en[0] = 1'b0;
    wait_idle(0, n);
    check("b2b_total", 32'(n), 32'd119);

    // Reset during data bit 3 with a second word queued
    din[0] = 9'h0C6; en[0] = 1'b1;
    tick();
    din[0] = 9'h099;
    tick();
    en[0] = 1'b0;
    repeat (16) tick();
    check("mid_bit3", 32'(tx[0]), 32'd0);
    check("mid_level", 32'(level[0]), 32'd1);
    reset = 1'b0;
    tick();
    check("mid_rst_tx",    32'(tx[0]),    32'd1);
    check("mid_rst_level", 32'(level[0]), 32'd0);
    check("mid_rst_busy",  32'(busy[0]),  32'd0);
    reset = 1'b1;
    tick();
    send_one(0, 9'h0A3, 40);

    // 5N1 at DIV=2
    send_one(3, 9'h01F, 14);

    repeat (5) tick();
    check("frames0", 32'(g_dut[0].frames), 32'd10);
    check("frames1", 32'(g_dut[1].frames), 32'd1);
    check("frames2", 32'(g_dut[2].frames), 32'd1);
    check("frames3", 32'(g_dut[3].frames), 32'd1);
    check("pending0", 32'(g_dut[0].q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter for the MIPS peripheral bus. It replaces the two-clock sender with a single-clock design that has an internal baud divider. Data width, parity and stop-bit count are configurable, and a small transmit FIFO lets the CPU queue several bytes without polling between them. It sits between the peripheral write decoder and the board TX pin.

## Interface
- `DIV`, default 5208: sysclk cycles per bit (50 MHz / 9600); legal values ≥ 2.
- `DATA_BITS`, default 8: payload bits per frame; legal range 5–9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `FIFO_DEPTH`, default 4: queue entries; power of two, ≥ 2.
- `sysclk` in 1: sole clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-low reset (asserted when 0).
- `TX_DATA` in DATA_BITS: word to queue.
- `TX_EN` in 1: write strobe; one word per cycle high.
- `TX_STATUS` out 1: 1 = FIFO not full, write will be accepted.
- `TX_BUSY` out 1: 1 = frame on the line or FIFO non-empty.
- `TX_OVF` out 1: one-cycle pulse when a write is dropped on a full FIFO.
- `TX_LEVEL` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `TX` out 1: serial line, idle high.

## Operation
- Reset values: `TX`=1, `TX_STATUS`=1, `TX_BUSY`=0, `TX_OVF`=0, `TX_LEVEL`=0; FIFO emptied; FSM in IDLE; divider cleared.
- Write accepted on an edge where `TX_EN`=1 and `TX_STATUS`=1. Data is copied into the FIFO tail.
- Write on full (`TX_EN`=1, `TX_STATUS`=0):
  - word dropped, FIFO unchanged;
  - `TX_OVF`=1 for the next cycle.
- `TX_STATUS` is computed from the registered level. If a pop and a push occur on the same edge while full, the push is still rejected.
- FSM states: IDLE → START → DATA → (PARITY if PARITY≠0) → STOP → IDLE, or STOP → START when the FIFO is non-empty at the end of STOP.
- IDLE:
  - `TX`=1;
  - if the FIFO is non-empty, pop the head into the shift register, load the divider, drive `TX`=0 and enter START.
- Each bit lasts exactly `DIV` cycles. The divider counts 0..DIV-1, and the bit advances at DIV-1.
- DATA:
  - bits sent LSB first;
  - `DATA_BITS` bits, tracked by a bit index of width $clog2(DATA_BITS).
- PARITY bit:
  - even parity = XOR of all data bits;
  - odd parity = its inverse.
- STOP: `TX`=1 for `STOP_BITS`×`DIV` cycles.
- Frame length F = DIV×(1+DATA_BITS+(PARITY≠0)+STOP_BITS) cycles. Back-to-back frames have zero idle gap.
- `TX_BUSY` = (state≠IDLE) | (level≠0).
- `TX_DATA` changes after acceptance do not affect queued data.
- Reset mid-frame: on the next edge `TX`=1 and the FIFO is cleared. The truncated frame is abandoned, with no completion.

## Timing
- Accept edge E0 into an empty FIFO with the FSM in IDLE:
  - `TX_LEVEL`=1 after E0;
  - pop at E1, so `TX_LEVEL`=0 and `TX`=0 after E1;
  - the start bit occupies cycles E1..E1+DIV-1.
- Last stop cycle ends at E1+F. A queued word's start bit begins on that same edge.
- `TX` is driven directly from a flop, so the pin output has no combinational path.
- Throughput: one word per F cycles.
- Writes are allowed every cycle until the FIFO is full.

## Structure
- Shared package `uart_pkg`:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - parity constants `PAR_NONE`=0, `PAR_ODD`=1, `PAR_EVEN`=2.
- Sub-module `sync_fifo`:
  - parameters WIDTH and DEPTH;
  - ports: push/pop/full/empty/level;
  - synchronous active-low reset;
  - reused later by the UART receiver.
- Top module: divider, bit counter, shift register, parity accumulator and FSM. Expected size ~200 lines including the FIFO.

## Test plan
- **Single frame, no parity.** Settings: DIV=4, 8N1. Write 0x55 → after E1, `TX` sequence 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles; `TX_BUSY` falls 40 cycles after E1.
- **Even parity, 2 stop bits.** Settings: DIV=4, 8E2. Write 0x07 → parity bit 1; frame 48 cycles. With odd parity (8O1), the parity bit is 0.
- **FIFO fill and overflow.** Settings: DIV=4, FIFO_DEPTH=4. Issue six consecutive writes 0x01..0x06 → first five accepted (0x01 popped at E1). The sixth is dropped, `TX_OVF` pulses once, and `TX_STATUS`=0 while the level is 4.
- **Back-to-back frames.** Queue three words with 8N1, DIV=4 → `TX` has no idle-high cycle between stop and the next start; total 120 cycles from E1 to `TX_BUSY`=0.
- **Reset mid-frame.** Pull `reset` low during data bit 3 → `TX`=1 and `TX_LEVEL`=0 on the next edge. After release, a new write of 0xA3 transmits cleanly.
- **Data width 5.** Settings: DATA_BITS=5, 5N1, DIV=2. Write 0x1F → 5 high data bits after the start bit; frame 14 cycles.
